// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage.
//   - opcode constants for the load/store instructions
//   - data bus size encodings
//   - bus-transaction FSM state enum
//   - decode helpers mapping an opcode to access size and signedness
package mem_access_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_DRAIN
  } mem_state_e;

  // Anything that is not a recognised byte/half opcode is a word access.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      default:              sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and extension (purely combinational).
// Ports:
//   rdata      in  32  raw bus read data
//   addr_lo    in  2   byte offset of the load address
//   opcode     in  6   load opcode (size and sign)
//   load_data  out 32  lane-aligned, sign/zero-extended result
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  output logic [31:0] load_data
);

  logic [31:0] lane;
  logic [1:0]  size;
  logic        sgn;

  always_comb begin
    size = op_size(opcode);
    sgn  = op_signed(opcode);
    lane = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: load_data = {{24{sgn & lane[7]}}, lane[7:0]};
      SIZE_HALF: load_data = {{16{sgn & lane[15]}}, lane[15:0]};
      default:   load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage control: decodes the registered M-stage load/store,
// drives a single-outstanding req/addr_ok/data_ok data bus, returns aligned and
// extended load data, flags address errors and requests pipeline stalls.
// Optional feature macro: MEM_PERF_CNT_EN (adds perf_access_cnt/perf_stall_cnt).
// Ports:
//   clk, rst (async, active-low)
//   flushM, stallM, mem_readM, mem_writeM, aluoutM, rt_valueM, instrM : M-stage inputs
//   data_req/wr/size/addr/wstrb/wdata, data_addr_ok/data_ok/rdata     : data bus
//   load_dataM, mem_stallM, adelM, adesM, badvaddrM                    : results
//
// state    | meaning
// IDLE     | no transaction; request issued combinationally when access valid
// ADDR     | request pending, waiting for addr_ok; bus fields held from issue
// DATA     | address accepted, waiting for data_ok
// DONE     | response captured while pipeline stalled elsewhere; no request
// DRAIN    | instruction flushed with transaction in flight; discard response
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushM,
  input  logic              stallM,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] rt_valueM,
  input  logic [31:0]       instrM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] load_dataM,
  output logic              mem_stallM,
  output logic              adelM,
  output logic              adesM,
`ifdef MEM_PERF_CNT_EN
  output logic [31:0]       perf_access_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic [ADDR_W-1:0] badvaddrM
);

  mem_state_e state_q, state_d;

  // Bus fields captured at issue so the request stays stable in ADDR and the
  // response is aligned with the issuing instruction's offset and opcode.
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [1:0]        req_size_q, req_size_d;
  logic              req_wr_q, req_wr_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [5:0]        req_op_q, req_op_d;
  logic [DATA_W-1:0] done_q, done_d;

  logic [5:0]        opcode;
  logic [1:0]        cur_size;
  logic [3:0]        cur_wstrb;
  logic [DATA_W-1:0] cur_wdata;
  logic              misalign;
  logic              access_valid;
  logic [DATA_W-1:0] align_in;
  logic [DATA_W-1:0] aligned;
  logic              unused_instr;

  assign unused_instr = ^instrM[25:0];
  assign opcode       = instrM[31:26];

  always_comb begin
    cur_size = op_size(opcode);
    misalign = ((cur_size == SIZE_HALF) && aluoutM[0]) ||
               ((cur_size == SIZE_WORD) && (aluoutM[1:0] != 2'b00));
    adelM        = mem_readM & misalign;
    adesM        = mem_writeM & misalign;
    badvaddrM    = (adelM | adesM) ? aluoutM : '0;
    access_valid = (mem_readM | mem_writeM) & ~adelM & ~adesM & ~flushM;

    cur_wstrb = 4'b0000;
    cur_wdata = rt_valueM;
    case (cur_size)
      SIZE_BYTE: begin
        if (mem_writeM) cur_wstrb = 4'b0001 << aluoutM[1:0];
        cur_wdata = {4{rt_valueM[7:0]}};
      end
      SIZE_HALF: begin
        if (mem_writeM) cur_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
        cur_wdata = {2{rt_valueM[15:0]}};
      end
      default: begin
        if (mem_writeM) cur_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    if (state_q == ST_ADDR) begin
      data_req   = 1'b1;
      data_wr    = req_wr_q;
      data_size  = req_size_q;
      data_addr  = req_addr_q;
      data_wstrb = req_wstrb_q;
      data_wdata = req_wdata_q;
    end else begin
      data_req   = (state_q == ST_IDLE) & access_valid;
      data_wr    = mem_writeM;
      data_size  = cur_size;
      data_addr  = aluoutM;
      data_wstrb = cur_wstrb;
      data_wdata = cur_wdata;
    end

    mem_stallM = ((state_q == ST_IDLE) & access_valid) |
                 (state_q == ST_ADDR) |
                 ((state_q == ST_DATA) & ~data_data_ok) |
                 (state_q == ST_DRAIN);
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_size_d  = req_size_q;
    req_wr_d    = req_wr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    req_op_d    = req_op_q;
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        if (access_valid) begin
          req_addr_d  = aluoutM;
          req_size_d  = cur_size;
          req_wr_d    = mem_writeM;
          req_wstrb_d = cur_wstrb;
          req_wdata_d = cur_wdata;
          req_op_d    = opcode;
          state_d     = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (data_addr_ok) state_d = flushM ? ST_DRAIN : ST_DATA;
        else if (flushM)  state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (data_data_ok) begin
          if (!flushM && stallM) begin
            done_d  = data_rdata;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (flushM) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!stallM || flushM) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_size_q  <= SIZE_WORD;
      req_wr_q    <= 1'b0;
      req_wstrb_q <= 4'b0000;
      req_wdata_q <= '0;
      req_op_q    <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_size_q  <= req_size_d;
      req_wr_q    <= req_wr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      req_op_q    <= req_op_d;
      done_q      <= done_d;
    end
  end

  assign align_in = (state_q == ST_DONE) ? done_q : data_rdata;

  mem_load_align u_align (
    .rdata     (align_in),
    .addr_lo   (req_addr_q[1:0]),
    .opcode    (req_op_q),
    .load_data (aligned)
  );

  assign load_dataM = ((state_q == ST_DATA) || (state_q == ST_DONE)) ? aligned : '0;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_access_q, perf_access_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_access_d = perf_access_q;
    perf_stall_d  = perf_stall_q;
    if (data_req && data_addr_ok && (state_q != ST_DRAIN)) perf_access_d = perf_access_q + 32'd1;
    if (mem_stallM) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_access_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_access_q <= perf_access_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_access_cnt = perf_access_q;
  assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// load/store transactions against a transaction-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushM, stallM, mem_readM, mem_writeM;
  logic [31:0] aluoutM, rt_valueM, instrM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] load_dataM;
  logic        mem_stallM, adelM, adesM;
  logic [31:0] badvaddrM;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_access_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flushM       (flushM),
    .stallM       (stallM),
    .mem_readM    (mem_readM),
    .mem_writeM   (mem_writeM),
    .aluoutM      (aluoutM),
    .rt_valueM    (rt_valueM),
    .instrM       (instrM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .load_dataM   (load_dataM),
    .mem_stallM   (mem_stallM),
    .adelM        (adelM),
    .adesM        (adesM),
`ifdef MEM_PERF_CNT_EN
    .perf_access_cnt (perf_access_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .badvaddrM    (badvaddrM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 0;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [5:0] op);
    logic [31:0] v;
    int sz;
    sz = size_of(op);
    v  = rdata >> (8 * int'(addr[1:0]));
    if (sz == 0) begin
      v = v % 256;
      if (op == 6'h20 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (op == 6'h21 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] strobe_model(input int sz, input logic [31:0] addr);
    if (sz == 0) return 32'(1) << addr[1:0];
    if (sz == 1) return (addr[1:0] == 2'd2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] wdata_model(input int sz, input logic [31:0] rt);
    if (sz == 0) return (rt % 256) * 32'h0101_0101;
    if (sz == 1) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flushM       = 1'b0;
    stallM       = 1'b0;
    mem_readM    = 1'b0;
    mem_writeM   = 1'b0;
    aluoutM      = $urandom;
    rt_valueM    = $urandom;
    instrM       = $urandom;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
  endtask

  task automatic drive_instr(input logic rd, input logic wr, input logic [5:0] op,
                             input logic [31:0] addr, input logic [31:0] rt);
    logic [31:0] r;
    r          = $urandom;
    mem_readM  = rd;
    mem_writeM = wr;
    instrM     = {op, r[25:0]};
    aluoutM    = addr;
    rt_valueM  = rt;
    flushM     = 1'b0;
  endtask

  // One complete access. a_lat: request cycles before addr_ok; d_lat: cycles
  // from addr_ok to data_ok (>=1); hold: cycles another source keeps stallM.
  task automatic do_access(input logic rd, input logic wr, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rdata, input int a_lat, input int d_lat,
                           input int hold);
    int sz;
    bit mis;
    logic [31:0] exp_ld;
    sz     = size_of(op);
    mis    = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'd0);
    exp_ld = ext_model(rdata, addr, op);
    drive_instr(rd, wr, op, addr, rt);
    if (mis) begin
      stallM = 1'b0;
      @(negedge clk);
      check("adel", 32'(adelM), 32'(rd));
      check("ades", 32'(adesM), 32'(wr));
      check("badvaddr", badvaddrM, addr);
      check("req_misaligned", 32'(data_req), 32'd0);
      check("stall_misaligned", 32'(mem_stallM), 32'd0);
      step();
      idle_inputs();
      return;
    end
    for (int i = 0; i <= a_lat; i++) begin
      stallM       = 1'b1;
      data_addr_ok = (i == a_lat);
      @(negedge clk);
      check("req", 32'(data_req), 32'd1);
      check("stall_addr", 32'(mem_stallM), 32'd1);
      check("wr", 32'(data_wr), 32'(wr));
      check("size", 32'(data_size), 32'(sz));
      check("addr", data_addr, addr);
      check("wstrb", 32'(data_wstrb), wr ? strobe_model(sz, addr) : 32'd0);
      if (wr) check("wdata", data_wdata, wdata_model(sz, rt));
      check("no_exc", 32'(adelM | adesM), 32'd0);
      check("badv_zero", badvaddrM, 32'd0);
      step();
    end
    data_addr_ok = 1'b0;
    for (int j = 1; j <= d_lat; j++) begin
      data_data_ok = (j == d_lat);
      data_rdata   = (j == d_lat) ? rdata : $urandom;
      stallM       = (j < d_lat) ? 1'b1 : (hold > 0);
      @(negedge clk);
      check("stall_data", 32'(mem_stallM), 32'(j < d_lat));
      check("req_data", 32'(data_req), 32'd0);
      if (j == d_lat && rd) check("load", load_dataM, exp_ld);
      step();
    end
    data_data_ok = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      data_rdata = $urandom;
      stallM     = (k < hold);
      @(negedge clk);
      check("done_req", 32'(data_req), 32'd0);
      check("done_stall", 32'(mem_stallM), 32'd0);
      if (rd) check("done_load", load_dataM, exp_ld);
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("idle_load", load_dataM, 32'd0);
    check("idle_stall", 32'(mem_stallM), 32'd0);
    step();
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(mem_stallM), 32'd0);
    check("rst_load", load_dataM, 32'd0);
    rst = 1'b1;
    step();

    // Directed scenarios.
    do_access(1, 0, 6'h23, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
    do_access(1, 0, 6'h20, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1, 0);
    do_access(1, 0, 6'h24, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 1, 0);
    do_access(0, 1, 6'h29, 32'h0000_2002, 32'h0000_1234, 32'h0, 0, 1, 0);
    do_access(1, 0, 6'h23, 32'h0000_1001, 32'h0, 32'h0, 0, 1, 0);
    do_access(0, 1, 6'h2B, 32'h0000_1002, 32'h5555_AAAA, 32'h0, 0, 1, 0);
    do_access(1, 0, 6'h21, 32'h0000_4002, 32'h0, 32'h9ABC_0000, 2, 2, 3);

    // Flush while waiting for data_ok: response must be drained and dropped.
    drive_instr(1, 0, 6'h23, 32'h0000_3000, 32'h0);
    stallM = 1'b1; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    check("flush_data_stall", 32'(mem_stallM), 32'd1);
    step();
    idle_inputs(); stallM = 1'b1;
    @(negedge clk);
    check("drain_stall", 32'(mem_stallM), 32'd1);
    check("drain_req", 32'(data_req), 32'd0);
    check("drain_load", load_dataM, 32'd0);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678; stallM = 1'b1;
    @(negedge clk);
    check("drain_ok_load", load_dataM, 32'd0);
    check("drain_ok_stall", 32'(mem_stallM), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("post_drain_stall", 32'(mem_stallM), 32'd0);
    check("post_drain_load", load_dataM, 32'd0);
    step();

    // Flush while the request is still waiting for addr_ok.
    drive_instr(1, 0, 6'h23, 32'h0000_5000, 32'h0);
    stallM = 1'b1;
    step();
    flushM = 1'b1;
    @(negedge clk);
    check("flush_addr_req", 32'(data_req), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("post_flush_addr_req", 32'(data_req), 32'd0);
    check("post_flush_addr_stall", 32'(mem_stallM), 32'd0);
    step();

    // Reset in the middle of a transaction.
    drive_instr(1, 0, 6'h23, 32'h0000_6000, 32'h0);
    stallM = 1'b1; data_addr_ok = 1'b1;
    step();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(data_req), 32'd0);
    check("midrst_stall", 32'(mem_stallM), 32'd0);
    check("midrst_load", load_dataM, 32'd0);
    step();
    rst = 1'b1;
    step();
    do_access(1, 0, 6'h25, 32'h0000_7002, 32'h0, 32'hF00D_0000, 0, 1, 0);

    // Randomized transactions.
    for (int t = 0; t < 120; t++) begin
      logic [5:0] op;
      logic rd, wr;
      int hold;
      op = ops[$urandom_range(0, 9)];
      if (op == 6'h00 || op == 6'h0F) begin
        rd = $urandom_range(0, 1);
      end else begin
        rd = (op < 6'h28);
      end
      wr   = ~rd;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_access(rd, wr, op, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 4), hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
